// File: rtl/selftrigger_threshold_bank_pkg.sv
// Shared definitions for the self-trigger threshold bank.
//   - trig_state_e : per-channel trigger FSM states
//   - SEL_*        : cfg_sel field encodings for the register port
//   - THR_RESET_DEFAULT : reset threshold, high enough that the trigger is disabled
package selftrigger_threshold_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HOLDOFF = 2'd2,
    ST_REARM   = 2'd3
  } trig_state_e;

  localparam logic [1:0] SEL_THR  = 2'd0;
  localparam logic [1:0] SEL_HYST = 2'd1;
  localparam logic [1:0] SEL_CNT  = 2'd2;
  localparam logic [1:0] SEL_MASK = 2'd3;

  localparam int THR_RESET_DEFAULT = 99999;

endpackage

// File: rtl/selftrigger_threshold_bank_channel_fsm.sv
// Trigger logic for a single channel: threshold/hysteresis compare,
// minimum-width confirmation, hold-off dead time, re-arm, registered
// one-cycle trigger pulse and a saturating trigger counter.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   active_i       global enable AND channel mask; low parks the FSM in IDLE
//   x_i            signed sample
//   thr_i, hyst_i  signed threshold and hysteresis
//   cnt_clr_i      clear the trigger counter (wins over a simultaneous fire)
//   trigger_o      registered one-cycle trigger pulse
//   count_o        saturating trigger count
module selftrigger_channel_fsm
  import selftrigger_threshold_bank_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned THR_W     = 32,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MIN_WIDTH = 2,
  parameter int unsigned HOLDOFF   = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     active_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [THR_W-1:0]  thr_i,
  input  logic signed [THR_W-1:0]  hyst_i,
  input  logic                     cnt_clr_i,
  output logic                     trigger_o,
  output logic [CNT_W-1:0]         count_o
);

  localparam int unsigned CONF_W = $clog2(MIN_WIDTH + 1);
  localparam int unsigned HO_W   = $clog2(HOLDOFF + 1);
  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(MIN_WIDTH);
  localparam logic [HO_W-1:0]   HO_LAST   = HO_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic signed [THR_W-1:0] x_ext;
  logic signed [THR_W:0]   x_wide;
  logic signed [THR_W:0]   floor_wide;
  logic                    above;
  logic                    below;

  assign x_ext      = THR_W'(x_i);
  assign x_wide     = (THR_W + 1)'(x_i);
  // One extra bit so threshold - hysteresis cannot wrap.
  assign floor_wide = (THR_W + 1)'(thr_i) - (THR_W + 1)'(hyst_i);
  assign above      = x_ext > thr_i;
  assign below      = x_wide <= floor_wide;

  trig_state_e       state_q, state_d;
  logic [CONF_W-1:0] conf_q, conf_d, conf_inc;
  logic [HO_W-1:0]   ho_q, ho_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              trig_q;
  logic              fire;

  assign conf_inc = conf_q + CONF_W'(1);

  always_comb begin
    state_d = state_q;
    conf_d  = conf_q;
    ho_d    = ho_q;
    fire    = 1'b0;
    if (!active_i) begin
      state_d = ST_IDLE;
      conf_d  = '0;
      ho_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (above) begin
            if (MIN_WIDTH == 1) begin
              fire    = 1'b1;
              state_d = ST_HOLDOFF;
              ho_d    = '0;
            end else begin
              state_d = ST_CONFIRM;
              conf_d  = CONF_W'(1);
            end
          end
        end
        ST_CONFIRM: begin
          if (above) begin
            if (conf_inc == CONF_LAST) begin
              fire    = 1'b1;
              state_d = ST_HOLDOFF;
              conf_d  = '0;
              ho_d    = '0;
            end else begin
              conf_d = conf_inc;
            end
          end else begin
            state_d = ST_IDLE;
            conf_d  = '0;
          end
        end
        ST_HOLDOFF: begin
          if (ho_q == HO_LAST) begin
            state_d = ST_REARM;
            ho_d    = '0;
          end else begin
            ho_d = ho_q + HO_W'(1);
          end
        end
        ST_REARM: begin
          if (below) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i)                      cnt_d = '0;
    else if (fire && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      conf_q  <= '0;
      ho_q    <= '0;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      conf_q  <= conf_d;
      ho_q    <= ho_d;
      cnt_q   <= cnt_d;
      trig_q  <= fire;
    end
  end

  assign trigger_o = trig_q;
  assign count_o   = cnt_q;

endmodule

// File: rtl/selftrigger_threshold_bank.sv
// Per-channel self-trigger stage for the pedestal-recovered sample stream.
// Holds the threshold / hysteresis / mask register bank, the registered
// read port, and NUM_CH channel trigger FSMs.
// Ports:
//   clk, reset_n   sample clock, asynchronous active-low reset
//   enable         global run; low parks every FSM in IDLE
//   x              packed signed samples, channel c at [c*DATA_W +: DATA_W]
//   cfg_wr/cfg_rd  single-cycle write / read strobes
//   cfg_ch/cfg_sel channel index and field (threshold, hysteresis, counter, mask)
//   cfg_wdata      write data; counter write clears, mask write uses bit 0
//   cfg_rdata      read data, one cycle after cfg_rd
//   cfg_rvalid     one-cycle read-valid pulse
//   trigger        one-cycle trigger pulse per channel
module selftrigger_threshold_bank
  import selftrigger_threshold_bank_pkg::*;
#(
  parameter int unsigned NUM_CH    = 40,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned THR_W     = 32,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MIN_WIDTH = 2,
  parameter int unsigned HOLDOFF   = 64,
  parameter int          THR_RESET = THR_RESET_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [NUM_CH*DATA_W-1:0]   x,
  input  logic                       cfg_wr,
  input  logic                       cfg_rd,
  input  logic [7:0]                 cfg_ch,
  input  logic [1:0]                 cfg_sel,
  input  logic [THR_W-1:0]           cfg_wdata,
  output logic [THR_W-1:0]           cfg_rdata,
  output logic                       cfg_rvalid,
  output logic [NUM_CH-1:0]          trigger
);

  logic signed [THR_W-1:0] thr_q  [NUM_CH];
  logic signed [THR_W-1:0] hyst_q [NUM_CH];
  logic [NUM_CH-1:0]       mask_q;
  logic [CNT_W-1:0]        cnt_w  [NUM_CH];
  logic [NUM_CH-1:0]       cnt_clr;
  logic [THR_W-1:0]        rd_val;
  logic [THR_W-1:0]        rdata_q;
  logic                    rvalid_q;

  // Out-of-range channel indices match no loop iteration, so writes are
  // dropped and reads fall through to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        thr_q[c]  <= THR_W'(THR_RESET);
        hyst_q[c] <= '0;
      end
      mask_q <= '1;
    end else if (cfg_wr) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (cfg_ch == 8'(c)) begin
          case (cfg_sel)
            SEL_THR:  thr_q[c]  <= cfg_wdata;
            SEL_HYST: hyst_q[c] <= cfg_wdata;
            SEL_MASK: mask_q[c] <= cfg_wdata[0];
            default:  ;
          endcase
        end
      end
    end
  end

  always_comb begin
    cnt_clr = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      cnt_clr[c] = cfg_wr && (cfg_sel == SEL_CNT) && (cfg_ch == 8'(c));
    end
  end

  // Read mux sees register values before this edge's write lands.
  always_comb begin
    rd_val = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (cfg_ch == 8'(c)) begin
        case (cfg_sel)
          SEL_THR:  rd_val = thr_q[c];
          SEL_HYST: rd_val = hyst_q[c];
          SEL_CNT:  rd_val = THR_W'(cnt_w[c]);
          default:  rd_val = THR_W'(mask_q[c]);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= cfg_rd;
      if (cfg_rd) rdata_q <= rd_val;
    end
  end

  assign cfg_rdata  = rdata_q;
  assign cfg_rvalid = rvalid_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    selftrigger_channel_fsm #(
      .DATA_W    (DATA_W),
      .THR_W     (THR_W),
      .CNT_W     (CNT_W),
      .MIN_WIDTH (MIN_WIDTH),
      .HOLDOFF   (HOLDOFF)
    ) u_fsm (
      .clk       (clk),
      .reset_n   (reset_n),
      .active_i  (enable & mask_q[c]),
      .x_i       (x[c*DATA_W +: DATA_W]),
      .thr_i     (thr_q[c]),
      .hyst_i    (hyst_q[c]),
      .cnt_clr_i (cnt_clr[c]),
      .trigger_o (trigger[c]),
      .count_o   (cnt_w[c])
    );
  end

endmodule

// File: doc/selftrigger_threshold_bank.md
Name: selftrigger_threshold_bank

Overview:
Parametrised per-channel self-trigger stage for the filtered (pedestal-recovered) sample stream, scaled from 40 fixed channels to NUM_CH.
- Holds a register bank of per-channel threshold and hysteresis values.
- Runs a per-channel trigger FSM with minimum-width confirmation, hold-off dead time and hysteresis re-arm.
- Keeps saturating per-channel trigger counters.
- Sits between the filter outputs and the readout/trigger-primitive logic; configured over a simple single-cycle register port.

Parameters:
NUM_CH, 40, number of channels
DATA_W, 16, signed sample width
THR_W, 32, signed threshold/hysteresis width
CNT_W, 32, trigger counter width
MIN_WIDTH, 2, consecutive above-threshold samples needed to fire (>=1)
HOLDOFF, 64, dead-time cycles after a trigger (>=1)
THR_RESET, 99999, reset threshold (trigger effectively disabled)

Ports:
clk  in  1  sample clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  global run; low forces all FSMs to IDLE, counters hold
x  in  NUM_CH*DATA_W  signed samples; channel c at bits [c*DATA_W +: DATA_W]
cfg_wr  in  1  register write strobe
cfg_rd  in  1  register read strobe
cfg_ch  in  8  channel index
cfg_sel  in  2  field select: 0 threshold, 1 hysteresis, 2 counter, 3 channel mask bit
cfg_wdata  in  THR_W  write data
cfg_rdata  out  THR_W  read data
cfg_rvalid  out  1  read data valid
trigger  out  NUM_CH  one-cycle trigger pulse per channel

Behaviour:
- Reset (async assert, sync release) values:
  - threshold = THR_RESET, hysteresis = 0, counter = 0, mask = 1 (enabled).
  - FSMs in IDLE; trigger = 0; cfg_rdata = 0; cfg_rvalid = 0.
- Compare: above = sign-extended x > threshold (THR_W signed). below = x <= threshold - hysteresis, computed at THR_W+1 bits with no wrap.
- FSM per channel, evaluated on each rising edge while enable=1 and mask=1:
  - IDLE: above -> CONFIRM with cnt=1. If MIN_WIDTH=1, go straight to HOLDOFF and fire.
  - CONFIRM: above -> cnt+1; when cnt reaches MIN_WIDTH, fire and enter HOLDOFF. Not above -> IDLE, cnt=0.
  - HOLDOFF: count HOLDOFF cycles, ignoring input, then -> REARM.
  - REARM: below -> IDLE. Otherwise stay; no retrigger on a long pulse.
- Fire:
  - trigger[c] is registered, high exactly one cycle: the cycle after the edge that sampled the MIN_WIDTH-th consecutive above sample.
  - counter[c] increments on fire and saturates at 2^CNT_W-1.
- enable=0 or mask=0: channel FSM goes to IDLE next edge; trigger forced 0; counter holds.
- Register writes (one cycle): threshold/hysteresis take effect for the compare on the following edge, including mid-CONFIRM.
  - Counter write clears the counter regardless of data.
  - Mask write uses bit 0.
- Register reads: cfg_rdata/cfg_rvalid are registered, 1-cycle latency. cfg_rvalid is high exactly one cycle per cfg_rd. Counter is zero-extended or truncated to THR_W.
- Simultaneous wr+rd to the same location: read returns the pre-write value.
- Counter clear and fire on the same edge: clear wins, counter = 0. Trigger still pulses.
- cfg_ch >= NUM_CH: write ignored; read returns 0 with cfg_rvalid=1.
- Reset asserted mid-operation: all state returns to reset values immediately; an in-flight trigger pulse is truncated.

Decomposition:
- Shared package: state enum (IDLE, CONFIRM, HOLDOFF, REARM), cfg_sel field constants, THR_RESET default.
- One sub-module, selftrigger_channel_fsm: compare, FSM, hold-off counter, trigger register and saturating counter for one channel.
- The top holds the register bank and read mux, and instantiates NUM_CH copies of selftrigger_channel_fsm.

Test Plan:
1. Reset then read ch 5 threshold -> cfg_rdata=99999 one cycle after cfg_rd, cfg_rvalid pulse of 1 cycle. With x=5000 constant, no trigger for 200 cycles.
2. ch 3 thr=100, MIN_WIDTH=2; x[3] = 50, 150, 150, 150 ... -> trigger[3] pulses once, one cycle after the 2nd 150 is sampled; counter[3]=1. A single-sample 150 glitch produces no trigger.
3. ch 3 thr=100, hyst=30, HOLDOFF=64; x stays 150 for 300 cycles, then 80, then 60, then 150 for 2 samples -> exactly one trigger during the 300 cycles. No re-arm at 80; re-arm at 60; second trigger after the two final 150s; counter=2.
4. Counter near saturation (CNT_W reduced to 4, 16 pulses) -> counter stays 15. Counter write on a fire edge -> counter 0 while trigger still pulses.
5. mask ch 7=0, or enable=0, during CONFIRM -> no trigger, FSM in IDLE, counter held. Re-enable -> fresh MIN_WIDTH confirmation required.
6. Write cfg_ch=45 (NUM_CH=40) -> no register changes; read returns 0 with cfg_rvalid. reset_n pulsed mid-HOLDOFF -> trigger and counters 0 immediately, thresholds back to 99999.
